// File: rtl/pcihellocore_pio_in_irq.sv
// Avalon-MM parallel input port with edge capture, optional per-bit debounce and
// a level interrupt built from the capture and mask registers.
module pcihellocore_pio_in_irq #(
  parameter int WIDTH           = 16,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      readdata_next;
  logic             wr_en;
  logic             unused_bits;

  // Upper writedata bits are intentionally ignored when WIDTH < 32.
  assign unused_bits = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
      assign filtered = sync2;
    end else begin : g_deb
      localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [15:0] count;
        logic        filt_bit;
        // A bit only follows sync2 after it has disagreed for N straight clocks.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            count    <= '0;
            filt_bit <= 1'b0;
          end else if (sync2[gi] != filt_bit) begin
            if (count == CNT_LAST) begin
              filt_bit <= sync2[gi];
              count    <= '0;
            end else begin
              count <= count + 16'd1;
            end
          end else begin
            count <= '0;
          end
        end
        assign filtered[gi] = filt_bit;
      end
    end
  endgenerate

  assign rise  = filtered & ~prev;
  assign fall  = ~filtered & prev;
  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edges = rise;
    if (EDGE_TYPE == 1) begin
      edges = fall;
    end else if (EDGE_TYPE == 2) begin
      edges = rise | fall;
    end
  end

  assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    readdata_next = '0;
    case (address)
      2'd0:    readdata_next = 32'(filtered);
      2'd2:    readdata_next = 32'(irqmask);
      2'd3:    readdata_next = 32'(edgecapture);
      default: readdata_next = '0;
    endcase
  end

  // New edges are OR-ed in after the clear so a simultaneous edge keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
      readdata    <= '0;
    end else begin
      prev        <= filtered;
      edgecapture <= (edgecapture & ~clear_bits) | edges;
      if (wr_en && address == 2'd2) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      readdata <= readdata_next;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule
